ex_stage: RTL and testbench

Execute stage of the five-stage in-order core: sits between the ID/EX pipeline register and the memory stage, and drives the EX_MEM_* bundle that the memory stage consumes. It resolves operands, including forwarding from EX/MEM and MEM/WB, and computes the ALU result. It registers the result together with the memory and writeback control signals. An optional iterative 32-cycle multiplier holds the pipeline through its own stall request.

---
 rtl/ex_pkg.sv | 26 ++
 rtl/ex_if.sv | 32 +++
 rtl/ex_mul_iter.sv | 58 +++++
 rtl/ex_stage.sv | 213 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM state type, datapath width.
// The iterative multiplier is compiled in only when EX_MUL_EN is defined.
package ex_pkg;

    localparam int EX_XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/ex_if.sv
// ID/EX pipeline-register bundle. The ID side (master) drives every field and the
// execute stage (slave) consumes it; a slot is meaningful only while ID_EX_enable_out is high.
interface ex_if import ex_pkg::*; #(
    parameter int XLEN = EX_XLEN
);
    logic            ID_EX_enable_out;
    logic [XLEN-1:0] ID_EX_PC;
    logic [XLEN-1:0] ID_EX_ReadData1;
    logic [XLEN-1:0] ID_EX_ReadData2;
    logic [XLEN-1:0] ID_EX_Imm;
    logic [4:0]      ID_EX_Rs1;
    logic [4:0]      ID_EX_Rs2;
    logic [4:0]      ID_EX_Rd;
    logic [3:0]      ID_EX_ALUOp;
    logic            ID_EX_ALUSrc;
    logic            ID_EX_MemRead;
    logic            ID_EX_MemWrite;
    logic            ID_EX_MemToReg;
    logic            ID_EX_RegWrite;

    modport master (
        output ID_EX_enable_out, ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
               ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_ALUOp, ID_EX_ALUSrc,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite
    );

    modport slave (
        input  ID_EX_enable_out, ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
               ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_ALUOp, ID_EX_ALUSrc,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite
    );
endinterface

// File: rtl/ex_mul_iter.sv
// Shift-and-add multiplier producing the low XLEN product bits, one multiplier bit per cycle.
// Used by ex_stage only when EX_MUL_EN is defined.
module ex_mul_iter import ex_pkg::*; #(
    parameter  int XLEN       = EX_XLEN,
    parameter  int MUL_CYCLES = 32,
    localparam int CW         = $clog2(MUL_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_product,
    output logic [CW-1:0]   o_cnt
);
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            w_last;

    // o_done marks the counter at its final iteration; it is meaningful only while busy.
    assign w_last    = (r_cnt == CW'(MUL_CYCLES - 1));
    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = r_acc;
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_clear) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
            if (w_last) r_busy <= 1'b0;
            else        r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM register. Define EX_MUL_EN to compile in
// the iterative multiplier and its IDLE/MUL/DONE control FSM.
module ex_stage import ex_pkg::*; #(
    parameter int XLEN       = EX_XLEN,
    parameter int MUL_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          combined_stall,
    input  logic                          flush,
    ex_if.slave                           id_ex,
    input  logic                          WB_enable,
    input  logic                          WB_RegWrite,
    input  logic [4:0]                    WB_Rd,
    input  logic [XLEN-1:0]               WB_Data,
    output logic [XLEN-1:0]               EX_MEM_PC,
    output logic [XLEN-1:0]               EX_MEM_ALUResult,
    output logic [XLEN-1:0]               EX_MEM_WriteData,
    output logic [4:0]                    EX_MEM_Rd,
    output logic                          EX_MEM_MemRead,
    output logic                          EX_MEM_MemWrite,
    output logic                          EX_MEM_MemToReg,
    output logic                          EX_MEM_RegWrite,
    output logic                          EX_MEM_enable_out,
    output logic                          ex_stall,
    output ex_state_e                     dbg_state,
    output logic [$clog2(MUL_CYCLES)-1:0] dbg_cnt
);
    logic            w_exm_fwd_ok;
    logic            w_wb_fwd_ok;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_kill;
    logic            w_issue;

    // A load in EX/MEM has no data yet; that hazard is stalled upstream, not forwarded.
    assign w_exm_fwd_ok = EX_MEM_enable_out && EX_MEM_RegWrite && !EX_MEM_MemRead && (EX_MEM_Rd != 5'd0);
    assign w_wb_fwd_ok  = WB_enable && WB_RegWrite && (WB_Rd != 5'd0);

    always_comb begin
        w_op_a = id_ex.ID_EX_ReadData1;
        if (w_exm_fwd_ok && EX_MEM_Rd == id_ex.ID_EX_Rs1)  w_op_a = EX_MEM_ALUResult;
        else if (w_wb_fwd_ok && WB_Rd == id_ex.ID_EX_Rs1) w_op_a = WB_Data;
        w_fwd_rs2 = id_ex.ID_EX_ReadData2;
        if (w_exm_fwd_ok && EX_MEM_Rd == id_ex.ID_EX_Rs2)  w_fwd_rs2 = EX_MEM_ALUResult;
        else if (w_wb_fwd_ok && WB_Rd == id_ex.ID_EX_Rs2) w_fwd_rs2 = WB_Data;
    end

    assign w_op_b  = id_ex.ID_EX_ALUSrc ? id_ex.ID_EX_Imm : w_fwd_rs2;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        case (id_ex.ID_EX_ALUOp)
            ALU_ADD:   w_alu = w_op_a + w_op_b;
            ALU_SUB:   w_alu = w_op_a - w_op_b;
            ALU_AND:   w_alu = w_op_a & w_op_b;
            ALU_OR:    w_alu = w_op_a | w_op_b;
            ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            ALU_SLL:   w_alu = w_op_a << w_shamt;
            ALU_SRL:   w_alu = w_op_a >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            ALU_PASSB: w_alu = w_op_b;
            default:   w_alu = '0;
        endcase
    end

    assign w_kill = flush;

`ifdef EX_MUL_EN
    ex_state_e       r_state;
    ex_state_e       w_state_nxt;
    logic            w_is_mul;
    logic            w_start;
    logic            w_retire;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_product;
    logic [XLEN-1:0] r_l_pc;
    logic [XLEN-1:0] r_l_wdata;
    logic [4:0]      r_l_rd;
    logic            r_l_memread;
    logic            r_l_memwrite;
    logic            r_l_memtoreg;
    logic            r_l_regwrite;

    assign w_is_mul  = id_ex.ID_EX_enable_out && (id_ex.ID_EX_ALUOp == ALU_MUL);
    assign ex_stall  = w_is_mul && (r_state != EX_DONE);
    assign dbg_state = r_state;

    ex_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst       (reset),
        .i_start   (w_start),
        .i_clear   (w_kill),
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product),
        .o_cnt     (dbg_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= EX_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Starting a multiply and the multiply itself ignore combined_stall; only retirement waits on it.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_retire    = 1'b0;
        if (w_kill) begin
            w_state_nxt = EX_IDLE;
        end else begin
            case (r_state)
                EX_IDLE: begin
                    if (w_is_mul) begin
                        w_start     = 1'b1;
                        w_state_nxt = EX_MUL;
                    end else if (!combined_stall) begin
                        w_issue = 1'b1;
                    end
                end
                EX_MUL:  if (w_mul_busy && w_mul_done) w_state_nxt = EX_DONE;
                EX_DONE: begin
                    if (!combined_stall) begin
                        w_retire    = 1'b1;
                        w_state_nxt = EX_IDLE;
                    end
                end
                default: w_state_nxt = EX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_pc       <= '0;
            r_l_wdata    <= '0;
            r_l_rd       <= '0;
            r_l_memread  <= 1'b0;
            r_l_memwrite <= 1'b0;
            r_l_memtoreg <= 1'b0;
            r_l_regwrite <= 1'b0;
        end else if (w_start) begin
            r_l_pc       <= id_ex.ID_EX_PC;
            r_l_wdata    <= w_fwd_rs2;
            r_l_rd       <= id_ex.ID_EX_Rd;
            r_l_memread  <= id_ex.ID_EX_MemRead;
            r_l_memwrite <= id_ex.ID_EX_MemWrite;
            r_l_memtoreg <= id_ex.ID_EX_MemToReg;
            r_l_regwrite <= id_ex.ID_EX_RegWrite;
        end
    end
`else
    assign w_issue   = !flush && !combined_stall;
    assign ex_stall  = 1'b0;
    assign dbg_state = EX_IDLE;
    assign dbg_cnt   = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_MEM_PC         <= '0;
            EX_MEM_ALUResult  <= '0;
            EX_MEM_WriteData  <= '0;
            EX_MEM_Rd         <= '0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemToReg   <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_enable_out <= 1'b0;
        end else if (w_kill) begin
            EX_MEM_enable_out <= 1'b0;
`ifdef EX_MUL_EN
        end else if (w_start) begin
            EX_MEM_enable_out <= 1'b0;
        end else if (w_retire) begin
            EX_MEM_PC         <= r_l_pc;
            EX_MEM_ALUResult  <= w_mul_product;
            EX_MEM_WriteData  <= r_l_wdata;
            EX_MEM_Rd         <= r_l_rd;
            EX_MEM_MemRead    <= r_l_memread;
            EX_MEM_MemWrite   <= r_l_memwrite;
            EX_MEM_MemToReg   <= r_l_memtoreg;
            EX_MEM_RegWrite   <= r_l_regwrite;
            EX_MEM_enable_out <= 1'b1;
`endif
        end else if (w_issue) begin
            EX_MEM_PC         <= id_ex.ID_EX_PC;
            EX_MEM_ALUResult  <= w_alu;
            EX_MEM_WriteData  <= w_fwd_rs2;
            EX_MEM_Rd         <= id_ex.ID_EX_Rd;
            EX_MEM_MemRead    <= id_ex.ID_EX_MemRead;
            EX_MEM_MemWrite   <= id_ex.ID_EX_MemWrite;
            EX_MEM_MemToReg   <= id_ex.ID_EX_MemToReg;
            EX_MEM_RegWrite   <= id_ex.ID_EX_RegWrite;
            EX_MEM_enable_out <= id_ex.ID_EX_enable_out;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiplier scenarios run when EX_MUL_EN is defined.
module tb_ex_stage;
    import ex_pkg::*;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 32;
    localparam int CW         = $clog2(MUL_CYCLES);

    logic            clk = 1'b0;
    logic            reset;
    logic            combined_stall;
    logic            flush;
    logic            WB_enable;
    logic            WB_RegWrite;
    logic [4:0]      WB_Rd;
    logic [XLEN-1:0] WB_Data;
    logic [XLEN-1:0] EX_MEM_PC;
    logic [XLEN-1:0] EX_MEM_ALUResult;
    logic [XLEN-1:0] EX_MEM_WriteData;
    logic [4:0]      EX_MEM_Rd;
    logic            EX_MEM_MemRead;
    logic            EX_MEM_MemWrite;
    logic            EX_MEM_MemToReg;
    logic            EX_MEM_RegWrite;
    logic            EX_MEM_enable_out;
    logic            ex_stall;
    ex_state_e       dbg_state;
    logic [CW-1:0]   dbg_cnt;

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [XLEN-1:0] pc_next = 32'h0000_1000;

    ex_if #(.XLEN(XLEN)) id_ex ();

    ex_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk               (clk),
        .reset             (reset),
        .combined_stall    (combined_stall),
        .flush             (flush),
        .id_ex             (id_ex),
        .WB_enable         (WB_enable),
        .WB_RegWrite       (WB_RegWrite),
        .WB_Rd             (WB_Rd),
        .WB_Data           (WB_Data),
        .EX_MEM_PC         (EX_MEM_PC),
        .EX_MEM_ALUResult  (EX_MEM_ALUResult),
        .EX_MEM_WriteData  (EX_MEM_WriteData),
        .EX_MEM_Rd         (EX_MEM_Rd),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_MemToReg   (EX_MEM_MemToReg),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_enable_out (EX_MEM_enable_out),
        .ex_stall          (ex_stall),
        .dbg_state         (dbg_state),
        .dbg_cnt           (dbg_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        id_ex.ID_EX_enable_out = 1'b0;
        id_ex.ID_EX_PC         = '0;
        id_ex.ID_EX_ReadData1  = '0;
        id_ex.ID_EX_ReadData2  = '0;
        id_ex.ID_EX_Imm        = '0;
        id_ex.ID_EX_Rs1        = '0;
        id_ex.ID_EX_Rs2        = '0;
        id_ex.ID_EX_Rd         = '0;
        id_ex.ID_EX_ALUOp      = '0;
        id_ex.ID_EX_ALUSrc     = 1'b0;
        id_ex.ID_EX_MemRead    = 1'b0;
        id_ex.ID_EX_MemWrite   = 1'b0;
        id_ex.ID_EX_MemToReg   = 1'b0;
        id_ex.ID_EX_RegWrite   = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic alusrc, input logic regwrite,
                         input logic memread);
        id_ex.ID_EX_enable_out = 1'b1;
        id_ex.ID_EX_PC         = pc_next;
        id_ex.ID_EX_ReadData1  = d1;
        id_ex.ID_EX_ReadData2  = d2;
        id_ex.ID_EX_Imm        = imm;
        id_ex.ID_EX_Rs1        = rs1;
        id_ex.ID_EX_Rs2        = rs2;
        id_ex.ID_EX_Rd         = rd;
        id_ex.ID_EX_ALUOp      = op;
        id_ex.ID_EX_ALUSrc     = alusrc;
        id_ex.ID_EX_MemRead    = memread;
        id_ex.ID_EX_MemWrite   = 1'b0;
        id_ex.ID_EX_MemToReg   = memread;
        id_ex.ID_EX_RegWrite   = regwrite;
        pc_next = pc_next + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (EX_MEM_enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", EX_MEM_enable_out); end
        n_tests++; if (EX_MEM_ALUResult !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", EX_MEM_ALUResult); end
        n_tests++; if (EX_MEM_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", EX_MEM_PC); end
        n_tests++; if ({EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg} !== 9'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg}); end
        n_tests++; if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", ex_stall); end
        n_tests++; if (dbg_state !== EX_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, EX_IDLE); end
        n_tests++; if (dbg_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dbg_cnt); end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [31:0] exp_pc;
        exp_pc = pc_next;
        issue(ALU_ADD, 5'd5, 5'd6, 5'd3, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd16) begin n_fail++; $display("FAIL add_result: got %h expected %h", EX_MEM_ALUResult, 32'd16); end
        n_tests++; if (EX_MEM_enable_out !== 1'b1) begin n_fail++; $display("FAIL add_enable: got %b expected 1", EX_MEM_enable_out); end
        n_tests++; if (EX_MEM_PC !== exp_pc || EX_MEM_Rd !== 5'd3 || EX_MEM_WriteData !== 32'd9 || EX_MEM_RegWrite !== 1'b1) begin
            n_fail++; $display("FAIL add_fields: got pc=%h rd=%0d wd=%h rw=%b expected pc=%h rd=3 wd=9 rw=1", EX_MEM_PC, EX_MEM_Rd, EX_MEM_WriteData, EX_MEM_RegWrite, exp_pc); end
        issue(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd100, 32'd9, 32'hFFFF_FFF6, 1'b1, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd90 || EX_MEM_WriteData !== 32'd9) begin
            n_fail++; $display("FAIL add_imm: got res=%h wd=%h expected res=%h wd=%h", EX_MEM_ALUResult, EX_MEM_WriteData, 32'd90, 32'd9); end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [14];
        logic [31:0] as [14];
        logic [31:0] bs [14];
        logic [31:0] es [14];
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA,
                ALU_SLT, ALU_SLT, ALU_SLTU, ALU_PASSB, 4'd13};
        as  = '{32'h7FFF_FFFF, 32'd5, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd1, 32'h8000_0000,
                32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd5};
        bs  = '{32'd1, 32'd7, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h23, 32'd4,
                32'd4, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'd6};
        es  = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'd8, 32'h0800_0000,
                32'hF800_0000, 32'h0400_0000, 32'd1, 32'd0, 32'd0, 32'h1234_5678, 32'd0};
        for (int i = 0; i < 14; i++) begin
            issue(ops[i], 5'd1, 5'd2, 5'd3, as[i], bs[i], 32'd0, 1'b0, 1'b1, 1'b0);
            tick();
            n_tests++;
            if (EX_MEM_ALUResult !== es[i] || EX_MEM_enable_out !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_op%0d_row%0d: got %h en=%b expected %h en=1", ops[i], i, EX_MEM_ALUResult, EX_MEM_enable_out, es[i]);
            end
        end
    endtask

    task automatic test_forwarding();
        issue(ALU_ADD, 5'd1, 5'd2, 5'd5, 32'h8, 32'h8, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        issue(ALU_SUB, 5'd5, 5'd6, 5'd7, 32'hDEAD, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'h0F) begin n_fail++; $display("FAIL fwd_exmem: got %h expected %h", EX_MEM_ALUResult, 32'h0F); end
        issue(ALU_PASSB, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1, 1'b0);
        tick();
        WB_enable = 1'b1; WB_RegWrite = 1'b1; WB_Rd = 5'd5; WB_Data = 32'h555;
        issue(ALU_ADD, 5'd5, 5'd0, 5'd8, 32'hBAD, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'h100) begin n_fail++; $display("FAIL fwd_priority: got %h expected %h", EX_MEM_ALUResult, 32'h100); end
        issue(ALU_ADD, 5'd5, 5'd5, 5'd9, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'hAAA || EX_MEM_WriteData !== 32'h555) begin
            n_fail++; $display("FAIL fwd_wb: got res=%h wd=%h expected res=%h wd=%h", EX_MEM_ALUResult, EX_MEM_WriteData, 32'hAAA, 32'h555); end
        WB_enable = 1'b0; WB_RegWrite = 1'b0; WB_Rd = 5'd0; WB_Data = 32'd0;
        issue(ALU_ADD, 5'd1, 5'd2, 5'd4, 32'h40, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        issue(ALU_ADD, 5'd4, 5'd0, 5'd6, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd3) begin n_fail++; $display("FAIL fwd_no_load: got %h expected %h", EX_MEM_ALUResult, 32'd3); end
        issue(ALU_ADD, 5'd1, 5'd2, 5'd0, 32'h99, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        issue(ALU_ADD, 5'd0, 5'd0, 5'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd7) begin n_fail++; $display("FAIL fwd_no_x0: got %h expected %h", EX_MEM_ALUResult, 32'd7); end
    endtask

    task automatic test_stall_flush();
        issue(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        combined_stall = 1'b1;
        issue(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd10, 32'd10, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd3 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got %h en=%b expected %h en=1", EX_MEM_ALUResult, EX_MEM_enable_out, 32'd3); end
        combined_stall = 1'b0;
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd20) begin n_fail++; $display("FAIL stall_release: got %h expected %h", EX_MEM_ALUResult, 32'd20); end
        bubble();
        tick();
        n_tests++; if (EX_MEM_enable_out !== 1'b0) begin n_fail++; $display("FAIL invalid_slot: got %b expected 0", EX_MEM_enable_out); end
        issue(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        n_tests++; if (EX_MEM_enable_out !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b expected 0", EX_MEM_enable_out); end
        flush = 1'b0;
        tick();
        combined_stall = 1'b1; flush = 1'b1;
        tick();
        n_tests++; if (EX_MEM_enable_out !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall: got %b expected 0", EX_MEM_enable_out); end
        combined_stall = 1'b0; flush = 1'b0;
        bubble();
        tick();
    endtask

    task automatic wait_stall(output int cycles, output int bad_en);
        cycles = 0;
        bad_en = 0;
        while (ex_stall === 1'b1 && cycles < 100) begin
            cycles++;
            if (EX_MEM_enable_out !== 1'b0) bad_en++;
            tick();
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int cyc;
        int bad;
        logic [31:0] exp_pc;
        exp_pc = pc_next;
        issue(ALU_MUL, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_stall(cyc, bad);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL mul_stall_len: got %0d cycles expected 33", cyc); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mul_wait_enable: got %0d cycles with enable high expected 0", bad); end
        n_tests++; if (dbg_state !== EX_DONE || EX_MEM_enable_out !== 1'b0) begin
            n_fail++; $display("FAIL mul_done_state: got st=%0d en=%b expected st=%0d en=0", dbg_state, EX_MEM_enable_out, EX_DONE); end
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'hFFFF_FFFD || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL mul_result: got %h en=%b expected %h en=1", EX_MEM_ALUResult, EX_MEM_enable_out, 32'hFFFF_FFFD); end
        n_tests++; if (EX_MEM_Rd !== 5'd10 || EX_MEM_PC !== exp_pc || EX_MEM_WriteData !== 32'd3 || dbg_state !== EX_IDLE) begin
            n_fail++; $display("FAIL mul_fields: got rd=%0d pc=%h wd=%h st=%0d expected rd=10 pc=%h wd=3 st=0", EX_MEM_Rd, EX_MEM_PC, EX_MEM_WriteData, dbg_state, exp_pc); end
        bubble();
        tick();
    endtask

    task automatic test_mul_stall_done();
        int cyc;
        int bad;
        issue(ALU_MUL, 5'd1, 5'd2, 5'd11, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_stall(cyc, bad);
        combined_stall = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (EX_MEM_enable_out !== 1'b0 || dbg_state !== EX_DONE) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mul_done_hold: got %0d bad cycles expected 0", bad); end
        combined_stall = 1'b0;
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd42 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL mul_done_release: got %h en=%b expected %h en=1", EX_MEM_ALUResult, EX_MEM_enable_out, 32'd42); end
        bubble();
        tick();
        n_tests++; if (EX_MEM_enable_out !== 1'b0 || dbg_state !== EX_IDLE) begin
            n_fail++; $display("FAIL mul_no_dup: got en=%b st=%0d expected en=0 st=0", EX_MEM_enable_out, dbg_state); end
    endtask

    task automatic test_mul_flush();
        int bad;
        issue(ALU_MUL, 5'd1, 5'd2, 5'd12, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        n_tests++; if (dbg_cnt !== CW'(10) || dbg_state !== EX_MUL) begin
            n_fail++; $display("FAIL mul_mid_cnt: got cnt=%0d st=%0d expected cnt=10 st=%0d", dbg_cnt, dbg_state, EX_MUL); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bubble();
        n_tests++; if (EX_MEM_enable_out !== 1'b0 || ex_stall !== 1'b0 || dbg_state !== EX_IDLE) begin
            n_fail++; $display("FAIL mul_flush: got en=%b stall=%b st=%0d expected en=0 stall=0 st=0", EX_MEM_enable_out, ex_stall, dbg_state); end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (EX_MEM_enable_out !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mul_flush_discard: got %0d cycles with enable high expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        issue(ALU_MUL, 5'd1, 5'd2, 5'd12, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_stall(cyc, bad);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd25 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got %h en=%b expected %h en=1", EX_MEM_ALUResult, EX_MEM_enable_out, 32'd25); end
        issue(ALU_MUL, 5'd1, 5'd2, 5'd13, 32'h1234, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0);
        wait_stall(cyc, bad);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL b2b_stall_len: got %0d cycles expected 33", cyc); end
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'h0012_3400 || EX_MEM_Rd !== 5'd13 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got %h rd=%0d en=%b expected %h rd=13 en=1", EX_MEM_ALUResult, EX_MEM_Rd, EX_MEM_enable_out, 32'h0012_3400); end
        bubble();
        tick();
    endtask
`else
    task automatic test_mul_disabled();
        issue(ALU_MUL, 5'd1, 5'd2, 5'd10, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (ex_stall !== 1'b0) begin n_fail++; $display("FAIL nomul_stall: got %b expected 0", ex_stall); end
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'd0 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL nomul_result: got %h en=%b expected 0 en=1", EX_MEM_ALUResult, EX_MEM_enable_out); end
        bubble();
        tick();
    endtask
`endif

    task automatic test_reset_then_sra();
        issue(ALU_MUL, 5'd1, 5'd2, 5'd14, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (dbg_state !== EX_IDLE || dbg_cnt !== '0 || EX_MEM_enable_out !== 1'b0 || EX_MEM_ALUResult !== 32'd0) begin
            n_fail++; $display("FAIL midreset: got st=%0d cnt=%0d en=%b res=%h expected all 0", dbg_state, dbg_cnt, EX_MEM_enable_out, EX_MEM_ALUResult); end
        bubble();
        @(negedge clk);
        reset = 1'b0;
        tick();
        issue(ALU_SRA, 5'd1, 5'd2, 5'd15, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_tests++; if (EX_MEM_ALUResult !== 32'hF800_0000 || EX_MEM_enable_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_sra: got %h en=%b expected %h en=1", EX_MEM_ALUResult, EX_MEM_enable_out, 32'hF800_0000); end
        bubble();
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        combined_stall = 1'b0;
        flush          = 1'b0;
        WB_enable      = 1'b0;
        WB_RegWrite    = 1'b0;
        WB_Rd          = 5'd0;
        WB_Data        = 32'd0;
        bubble();
        test_reset();
        test_add();
        test_alu_ops();
        test_forwarding();
        test_stall_flush();
`ifdef EX_MUL_EN
        test_mul();
        test_mul_stall_done();
        test_mul_flush();
        test_back_to_back();
`else
        test_mul_disabled();
`endif
        test_reset_then_sra();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
